// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl -- data-memory access sequencer for the MEM stage of the RV32 pipe.
//
// Accepts a load/store from the MEM stage, checks size/alignment, drives a
// req/gnt/rvalid memory port and holds the pipeline (o_stall) until the access
// retires with a one-cycle o_done. Loads return both the raw memory word and
// the aligned, sign/zero-extended lane; stores are posted on grant.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_vld           MEM-stage instruction valid
//   i_ren / i_wen       load / store (store wins if both set)
//   i_funct3            access size [1:0] and zero-extend flag [2]
//   i_addr, i_wdata     byte address, store data (rs2)
//   o_stall, o_done     pipeline hold, one-cycle completion
//   o_rdata             aligned/extended load result (held)
//   o_rdata_raw         raw memory word of last load (held)
//   o_mask, o_wdata     byte mask and replicated store data of last access
//   o_misaligned        misaligned request rejected, no access made
//   o_err               timeout or illegal funct3
//   o_mem_*/i_mem_*     memory port: req/gnt handshake, rvalid response
// -----------------------------------------------------------------------------
module dmem_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_vld,
   input  logic        i_ren,
   input  logic        i_wen,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_stall,
   output logic        o_done,
   output logic [31:0] o_rdata,
   output logic [31:0] o_rdata_raw,
   output logic [3:0]  o_mask,
   output logic [31:0] o_wdata,
   output logic        o_misaligned,
   output logic        o_err,
   output logic        o_mem_req,
   input  logic        i_mem_gnt,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_we,
   output logic [3:0]  o_mem_wmask,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_mem_rdata
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

   // Fields of the accepted access needed after the request has gone away.
   typedef struct packed {
      logic       we;
      logic [2:0] funct3;
      logic [1:0] lane;
   } acc_t;

   state_t          state;
   acc_t            acc_q;
   logic [CW-1:0]   tmo_cnt;
   logic [CW-1:0]   tmo_nxt;
   logic            tmo_hit;
   logic            err_q;

   logic            access;
   logic            legal;
   logic            misal;
   logic            is_idle;
   logic            accept;
   logic            ill_hit;
   logic            mis_hit;
   logic [3:0]      mask_nxt;
   logic [31:0]     wdata_nxt;

   // ---------------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------------
   assign access  = i_req_vld & (i_ren | i_wen);
   assign is_idle = (state == IDLE);

   always_comb begin
      legal = 1'b0;
      if (i_wen) begin
         legal = (i_funct3 == 3'b000) | (i_funct3 == 3'b001) | (i_funct3 == 3'b010);
      end else begin
         legal = (i_funct3 == 3'b000) | (i_funct3 == 3'b001) | (i_funct3 == 3'b010) |
                 (i_funct3 == 3'b100) | (i_funct3 == 3'b101);
      end
   end

   assign misal = ((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                  ((i_funct3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));

   always_comb begin
      mask_nxt  = 4'b1111;
      wdata_nxt = i_wdata;
      case (i_funct3[1:0])
         2'b00: begin
            mask_nxt  = 4'b0001 << i_addr[1:0];
            wdata_nxt = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            mask_nxt  = 4'b0011 << {i_addr[1], 1'b0};
            wdata_nxt = {2{i_wdata[15:0]}};
         end
         default: begin
            mask_nxt  = 4'b1111;
            wdata_nxt = i_wdata;
         end
      endcase
   end

   assign accept  = is_idle & access & legal & ~misal;
   assign ill_hit = is_idle & access & ~legal;
   assign mis_hit = is_idle & access & legal & misal;

   // Rejections complete in the same cycle without ever touching memory.
   assign o_stall      = accept | (state == REQ) | (state == WAIT_RSP);
   assign o_done       = (state == DONE) | ill_hit | mis_hit;
   assign o_misaligned = mis_hit;
   assign o_err        = err_q | ill_hit;

   // ---------------------------------------------------------------------------
   // Timeout: counts cycles spent in REQ + WAIT_RSP
   // ---------------------------------------------------------------------------
   assign tmo_nxt = tmo_cnt + 1'b1;
   assign tmo_hit = (tmo_nxt == CW'(TIMEOUT_CYC));

   // Load lane extraction. Halves are always lane-aligned here, so a plain
   // byte-granular shift serves both sizes.
   function automatic logic [31:0] load_ext(input logic [31:0] w,
                                            input logic [2:0]  f3,
                                            input logic [1:0]  lane);
      logic [31:0] s;
      logic [31:0] r;
      s = w >> {lane, 3'b000};
      case (f3[1:0])
         2'b00:   r = f3[2] ? {24'b0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
         2'b01:   r = f3[2] ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
         default: r = w;
      endcase
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // Access FSM with registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         acc_q       <= '0;
         tmo_cnt     <= '0;
         err_q       <= 1'b0;
         o_rdata     <= '0;
         o_rdata_raw <= '0;
         o_mask      <= '0;
         o_wdata     <= '0;
         o_mem_req   <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_we    <= 1'b0;
         o_mem_wmask <= '0;
         o_mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  acc_q.we     <= i_wen;
                  acc_q.funct3 <= i_funct3;
                  acc_q.lane   <= i_addr[1:0];
                  tmo_cnt      <= '0;
                  err_q        <= 1'b0;
                  o_mask       <= mask_nxt;
                  o_wdata      <= wdata_nxt;
                  o_mem_req    <= 1'b1;
                  o_mem_addr   <= {i_addr[31:2], 2'b00};
                  o_mem_we     <= i_wen;
                  o_mem_wmask  <= i_wen ? mask_nxt : 4'b0000;
                  o_mem_wdata  <= wdata_nxt;
                  state        <= REQ;
               end else if (ill_hit) begin
                  // keep the error visible until the next accepted access
                  err_q <= 1'b1;
               end
            end

            REQ: begin
               // rvalid is not looked at here; only the grant moves us on
               if (i_mem_gnt) begin
                  o_mem_req <= 1'b0;
                  o_mem_we  <= 1'b0;
                  tmo_cnt   <= tmo_nxt;
                  state     <= acc_q.we ? DONE : WAIT_RSP;
               end else if (tmo_hit) begin
                  o_mem_req   <= 1'b0;
                  o_mem_we    <= 1'b0;
                  err_q       <= 1'b1;
                  o_rdata     <= '0;
                  o_rdata_raw <= '0;
                  state       <= DONE;
               end else begin
                  tmo_cnt <= tmo_nxt;
               end
            end

            WAIT_RSP: begin
               if (i_mem_rvalid) begin
                  o_rdata_raw <= i_mem_rdata;
                  o_rdata     <= load_ext(i_mem_rdata, acc_q.funct3, acc_q.lane);
                  state       <= DONE;
               end else if (tmo_hit) begin
                  err_q       <= 1'b1;
                  o_rdata     <= '0;
                  o_rdata_raw <= '0;
                  state       <= DONE;
               end else begin
                  tmo_cnt <= tmo_nxt;
               end
            end

            DONE: begin
               // pipeline advances on this edge; a request seen now is ignored
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
